// File: rtl/payload_engine_pkg.sv
// Shared constants and helpers for the payload engine (class indices, clog2).
// Latency: n/a (package only).
// Backpressure: n/a.
package payload_engine_pkg;

    localparam int CLS_DIGIT    = 0;
    localparam int CLS_ALPHA    = 1;
    localparam int CLS_NOT_CRLF = 2;
    localparam int CLS_PIPE     = 3;
    localparam int CLS_SPACE    = 4;
    localparam int CLS_HEX      = 5;
    localparam int CLS_ANY      = 63;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/payload_nfa_cell.sv
// One NFA pattern position: active when its class hits and it is entered or self-loops.
// Latency: 1 cycle (s registered); s_nxt is the combinational next value.
// Backpressure: none; state holds while en is low.
module payload_nfa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic cls_bit,
    input  logic act,
    input  logic loop_en,
    output logic s,
    output logic s_nxt
);

    assign s_nxt = cls_bit & (act | (loop_en & s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 1'b0;
        end else if (en) begin
            s <= s_nxt;
        end
    end

endmodule

// File: rtl/payload_nfa_chain.sv
// Parametrised NFA chain matcher: per-position flops, first-match offset, per-packet result.
// Latency: byte at cycle t -> match/match_offset/result at t+1; one byte per cycle.
// Backpressure: none; en low freezes all state, result is a single-cycle pulse.
module payload_nfa_chain
    import payload_engine_pkg::*;
#(
    parameter int unsigned                      N_STATES  = 24,
    parameter int unsigned                      N_CLASSES = 64,
    parameter int unsigned                      CLS_W     = 6,
    parameter logic [N_STATES*CLS_W-1:0]        CLASS_IDX = '0,
    parameter logic [N_STATES-1:0]              LOOP_MASK = '0,
    parameter logic [N_STATES-1:0]              SKIP_MASK = '0,
    parameter bit                               ANCHORED  = 1'b1,
    parameter int unsigned                      OFFSET_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sod,
    input  logic                 eod,
    input  logic [N_CLASSES-1:0] cls,
    output logic                 match,
    output logic [OFFSET_W-1:0]  match_offset,
    output logic                 result_valid,
    output logic                 result_match
);

    localparam logic [OFFSET_W-1:0] OFF_MAX = '1;

    if (N_STATES < 2) begin : g_bad_len
        $error("payload_nfa_chain: N_STATES must be at least 2");
    end
    if (SKIP_MASK[N_STATES-1]) begin : g_bad_skip
        $error("payload_nfa_chain: last position cannot be skippable");
    end
    if (CLS_W < clog2(N_CLASSES)) begin : g_bad_clsw
        $error("payload_nfa_chain: CLS_W too narrow for N_CLASSES");
    end

    logic [N_STATES-1:0] s;
    logic [N_STATES-1:0] s_nxt;
    logic [N_STATES-1:0] s_prev;
    logic [N_STATES-1:0] act;
    logic [N_STATES-1:0] cls_sel;
    logic [N_STATES-1:0] loop_en;

    logic [OFFSET_W-1:0] cnt;
    logic [OFFSET_W-1:0] cur_off;
    logic [OFFSET_W-1:0] cnt_nxt;
    logic [OFFSET_W-1:0] off_base;
    logic [OFFSET_W-1:0] off_nxt;
    logic                match_base;
    logic                match_nxt;
    logic                accept;
    logic                first;
    logic                unused_cls;

    // Only the configured class lines are consumed; fold the rest away.
    assign unused_cls = ^cls;

    for (genvar i = 0; i < N_STATES; i++) begin : g_pos
        if (int'(CLASS_IDX[i*CLS_W +: CLS_W]) >= int'(N_CLASSES)) begin : g_bad_idx
            $error("payload_nfa_chain: CLASS_IDX entry out of range");
        end

        assign cls_sel[i] = cls[CLASS_IDX[i*CLS_W +: CLS_W]];
        // A start-of-data byte discards any in-flight partial match, including self-loops.
        assign loop_en[i] = LOOP_MASK[i] & ~sod;

        payload_nfa_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .cls_bit (cls_sel[i]),
            .act     (act[i]),
            .loop_en (loop_en[i]),
            .s       (s[i]),
            .s_nxt   (s_nxt[i])
        );
    end

    assign first = (cnt == '0);

    always_comb begin
        s_prev = sod ? '0 : s;
        act    = '0;
        act[0] = ANCHORED ? (sod | first) : 1'b1;
        for (int i = 1; i < int'(N_STATES); i++) begin
            act[i] = s_prev[i-1] | (SKIP_MASK[i-1] & act[i-1]);
        end
    end

    always_comb begin
        cur_off    = sod ? '0 : cnt;
        cnt_nxt    = (cur_off == OFF_MAX) ? OFF_MAX : cur_off + 1'b1;
        match_base = sod ? 1'b0 : match;
        off_base   = sod ? '0 : match_offset;
        accept     = s_nxt[N_STATES-1];
        match_nxt  = match_base | accept;
        // Only the first accept of a packet records the offset.
        off_nxt    = (accept & ~match_base) ? cur_off : off_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            match        <= 1'b0;
            match_offset <= '0;
            result_valid <= 1'b0;
            result_match <= 1'b0;
        end else begin
            result_valid <= en & eod;
            result_match <= en & eod & match_nxt;
            if (en) begin
                cnt          <= cnt_nxt;
                match        <= match_nxt;
                match_offset <= off_nxt;
            end
        end
    end

endmodule
